reg_write_arbiter: RTL and testbench

- Shares one bank of NREG 32-bit load-enabled registers between two write requesters (requester 0, requester 1).
- Arbitrates round-robin and latches the winner's address and data.
- Drives a single-cycle load enable to the addressed register, then returns a one-cycle acknowledge.
- Sits between the requesting control logic and the register bank's load-enable (C) and D inputs.

---
 rtl/reg_write_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Shares one bank of NREG load-enabled registers between two write
//   requesters. Arbitration is round-robin. The winner's address and data are
//   latched at grant. The block then drives a one-cycle one-hot load enable to
//   the addressed register, followed by a one-cycle acknowledge. All outputs
//   come straight from flops.
//
//   Optional feature: define ARB_LOCK_EN to add lock0/lock1 inputs. A granted
//   requester that holds its lock during ACK keeps priority for the next
//   arbitration, and the round-robin pointer is not advanced.
//
// Ports
//   clk          rising-edge clock
//   clear        asynchronous active-low reset
//   req0/req1    write requests, held high until the matching ack
//   addr0/addr1  target register index (AW bits)
//   data0/data1  write data (DW bits)
//   lock0/lock1  (ARB_LOCK_EN only) keep ownership across the next arbitration
//   ld           one-hot load enable, high only during WRITE
//   wdata        write data to every register D input; holds its last value
//   ack0/ack1    one-cycle completion pulses
//   err          pulses with the ack when the granted address is >= NREG
//   gnt          one-hot current owner, 0 when idle
//   busy         high in WRITE and ACK
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
`ifdef ARB_LOCK_EN
  input  logic            lock0,
  input  logic            lock1,
`endif
  output logic [NREG-1:0] ld,
  output logic [DW-1:0]   wdata,
  output logic            ack0,
  output logic            ack1,
  output logic            err,
  output logic [1:0]      gnt,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // One-hot decode of a register index; an index >= NREG decodes to all zeros.
  function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (a == AW'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // An index at or above NREG has no register behind it.
  function automatic logic addr_out_of_range(input logic [AW-1:0] a);
    return (int'(a) >= NREG);
  endfunction

  state_e          state_q, state_d;
  logic            last_q, last_d;          // last winner: 0 = requester 0, 1 = requester 1
  logic            err_flag_q, err_flag_d;
  logic [NREG-1:0] ld_q, ld_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            err_q, err_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            sel_s;                   // arbitration winner in IDLE
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_data_s;

`ifdef ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic            lock_own_q, lock_own_d;
  logic            lock_hit_s;
  logic            gnt_lock_s;
`endif

  // Next-state and next-output logic for the IDLE/WRITE/ACK sequence.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    err_flag_d = err_flag_q;
    ld_d       = '0;
    wdata_d    = wdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    sel_s      = 1'b0;
    win_addr_s = addr0;
    win_data_s = data0;
`ifdef ARB_LOCK_EN
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    lock_hit_s = lock_q && (lock_own_q ? req1 : req0);
    gnt_lock_s = gnt_q[1] ? lock1 : lock0;
`endif

    // Winner selection: lock owner first (if enabled), else the requester
    // that did not win last time, else whichever one is asking.
`ifdef ARB_LOCK_EN
    if (lock_hit_s) begin
      sel_s = lock_own_q;
    end else
`endif
    if (req0 && req1) begin
      sel_s = ~last_q;
    end else if (req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end

    if (sel_s) begin
      win_addr_s = addr1;
      win_data_s = data1;
    end else begin
      win_addr_s = addr0;
      win_data_s = data0;
    end

    case (state_q)
      ST_IDLE: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
`ifdef ARB_LOCK_EN
        // The lock lapses when its owner is idle with no request.
        if (lock_q && !lock_hit_s) begin
          lock_d = 1'b0;
        end else begin
          lock_d = lock_q;
        end
`endif
        if (req0 || req1) begin
          // ld is registered here so that it is high exactly during WRITE.
          ld_d       = addr_onehot(win_addr_s);
          err_flag_d = addr_out_of_range(win_addr_s);
          wdata_d    = win_data_s;
          gnt_d      = sel_s ? 2'b10 : 2'b01;
          busy_d     = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Registering the ack and err here makes them visible during ACK.
        if (gnt_q[1]) begin
          ack1_d = 1'b1;
        end else begin
          ack0_d = 1'b1;
        end
        err_d   = err_flag_q;
        busy_d  = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        gnt_d      = 2'b00;
        busy_d     = 1'b0;
        err_flag_d = 1'b0;
        state_d    = ST_IDLE;
`ifdef ARB_LOCK_EN
        if (gnt_lock_s) begin
          // Pointer frozen so the owner keeps priority next time.
          last_d     = last_q;
          lock_d     = 1'b1;
          lock_own_d = gnt_q[1];
        end else begin
          last_d     = gnt_q[1];
          lock_d     = 1'b0;
        end
`else
        last_d     = gnt_q[1];
`endif
      end
      default: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; clear drops everything immediately.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      err_flag_q <= 1'b0;
      ld_q       <= '0;
      wdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      err_flag_q <= err_flag_d;
      ld_q       <= ld_d;
      wdata_q    <= wdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
`ifdef ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
`endif
    end
  end

  assign ld    = ld_q;
  assign wdata = wdata_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err   = err_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Scoreboard bench. Expected transactions (winner, ld, wdata, err) are queued
//   when requests are driven. A monitor captures ld/wdata in the WRITE cycle and
//   compares against the queue head when an ack appears. A second instance with
//   NREG=3 exercises the out-of-range address path.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic        req0, req1;
  logic [1:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic [3:0]  ld;
  logic [31:0] wdata;
  logic        ack0, ack1, err, busy;
  logic [1:0]  gnt;

  logic        req0_b, req1_b;
  logic [1:0]  addr0_b, addr1_b;
  logic [31:0] data0_b, data1_b;
  logic [2:0]  ld_b;
  logic [31:0] wdata_b;
  logic        ack0_b, ack1_b, err_b, busy_b;
  logic [1:0]  gnt_b;

`ifdef ARB_LOCK_EN
  logic        lock0, lock1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  who;
    logic [3:0]  ld;
    logic [31:0] wd;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  reg_write_arbiter #(.NREG(4), .AW(2), .DW(32)) u_dut (
    .clk(clk), .clear(clear),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
`ifdef ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ld(ld), .wdata(wdata), .ack0(ack0), .ack1(ack1),
    .err(err), .gnt(gnt), .busy(busy)
  );

  reg_write_arbiter #(.NREG(3), .AW(2), .DW(32)) u_dut3 (
    .clk(clk), .clear(clear),
    .req0(req0_b), .addr0(addr0_b), .data0(data0_b),
    .req1(req1_b), .addr1(addr1_b), .data1(data1_b),
`ifdef ARB_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .ld(ld_b), .wdata(wdata_b), .ack0(ack0_b), .ack1(ack1_b),
    .err(err_b), .gnt(gnt_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_txn(input logic [1:0] who, input logic [3:0] l,
                          input logic [31:0] wd, input logic e);
    exp_t x;
    x.who = who; x.ld = l; x.wd = wd; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    cyc(1);
    clear = 1'b1;
    cyc(1);
  endtask

  // Monitor: capture the WRITE cycle, score each ack against the queue.
  initial begin
    logic [3:0]  cap_ld;
    logic [31:0] cap_wd;
    exp_t        e;
    cap_ld = '0;
    cap_wd = '0;
    forever begin
      @(negedge clk);
      if (clear) begin
        if (ack0 && ack1) check("ack_both", {ack1, ack0}, 2'b01);
        if (gnt != 2'b00 && !ack0 && !ack1) begin
          cap_ld = ld;
          cap_wd = wdata;
        end else begin
          check("ld_quiet", ld, 4'b0000);
        end
        if (ack0 || ack1) begin
          if (sbq.size() == 0) begin
            check("sb_empty", {ack1, ack0}, 2'b00);
          end else begin
            e = sbq.pop_front();
            check("sb_who", {ack1, ack0}, e.who);
            check("sb_gnt", gnt, e.who);
            check("sb_ld", cap_ld, e.ld);
            check("sb_wdata", cap_wd, e.wd);
            check("sb_err", err, e.err);
          end
        end
      end
    end
  end

  initial begin
    clear = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = 2'd0; addr1 = 2'd0; data0 = '0; data1 = '0;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = 2'd0; addr1_b = 2'd0; data0_b = '0; data1_b = '0;
`ifdef ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    #2;
    check("rst_ld", ld, 4'b0000);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ack", {ack1, ack0}, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    cyc(2);
    clear = 1'b1;
    cyc(1);

    // Single write, latency check.
    req0 = 1'b1; addr0 = 2'd2; data0 = 32'hDEADBEEF;
    push_txn(2'b01, 4'b0100, 32'hDEADBEEF, 1'b0);
    cyc(1);
    check("t1_ld", ld, 4'b0100);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_busy", busy, 1'b1);
    check("t1_ack_early", ack0, 1'b0);
    data0 = 32'h0BAD0BAD;                // ignored after grant
    cyc(1);
    check("t1_ack0", ack0, 1'b1);
    check("t1_err", err, 1'b0);
    check("t1_busy_ack", busy, 1'b1);
    req0 = 1'b0;
    cyc(1);
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_gnt", gnt, 2'b00);
    check("t1_hold_wdata", wdata, 32'hDEADBEEF);

    // Contention right after reset: requester 0 first.
    pulse_clear();
    req0 = 1'b1; addr0 = 2'd0; data0 = 32'hA0A00000;
    req1 = 1'b1; addr1 = 2'd3; data1 = 32'hB1B10001;
    push_txn(2'b01, 4'b0001, 32'hA0A00000, 1'b0);
    push_txn(2'b10, 4'b1000, 32'hB1B10001, 1'b0);
    cyc(1);
    check("t2_gnt_a", gnt, 2'b01);
    cyc(1);
    check("t2_ack0", ack0, 1'b1);
    req0 = 1'b0;
    cyc(1);
    check("t2_gnt_idle", gnt, 2'b00);
    cyc(1);
    check("t2_gnt_b", gnt, 2'b10);
    check("t2_ld_b", ld, 4'b1000);
    cyc(1);
    check("t2_ack1", ack1, 1'b1);
    req1 = 1'b0;
    cyc(1);

    // Both held high for four writes: grants alternate 0,1,0,1.
    req0 = 1'b1; addr0 = 2'd1; data0 = 32'h11110000;
    req1 = 1'b1; addr1 = 2'd2; data1 = 32'h22220000;
    push_txn(2'b01, 4'b0010, 32'h11110000, 1'b0);
    push_txn(2'b10, 4'b0100, 32'h22220000, 1'b0);
    push_txn(2'b01, 4'b0010, 32'h11110000, 1'b0);
    push_txn(2'b10, 4'b0100, 32'h22220000, 1'b0);
    cyc(11);
    check("t3_last_ack1", {ack1, ack0}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    cyc(1);
    check("t3_idle", busy, 1'b0);

    // Out-of-range address on the NREG=3 instance.
    req1_b = 1'b1; addr1_b = 2'd3; data1_b = 32'h12345678;
    cyc(1);
    check("t4_ld_w", ld_b, 3'b000);
    check("t4_gnt", gnt_b, 2'b10);
    check("t4_err_early", err_b, 1'b0);
    cyc(1);
    check("t4_ld_a", ld_b, 3'b000);
    check("t4_ack", {ack1_b, ack0_b}, 2'b10);
    check("t4_err", err_b, 1'b1);
    req1_b = 1'b0;
    cyc(1);
    check("t4_err_gone", err_b, 1'b0);
    check("t4_ack_gone", ack1_b, 1'b0);

    // Clear during WRITE aborts the transaction.
    req0 = 1'b1; addr0 = 2'd2; data0 = 32'h55AA55AA;
    cyc(1);
    check("t5_ld_w", ld, 4'b0100);
    #1 clear = 1'b0;
    #1;
    check("t5_ld_clr", ld, 4'b0000);
    check("t5_gnt_clr", gnt, 2'b00);
    check("t5_busy_clr", busy, 1'b0);
    req0 = 1'b0;
    cyc(2);
    check("t5_no_ack", {ack1, ack0}, 2'b00);
    clear = 1'b1;
    req0 = 1'b1; addr0 = 2'd3; data0 = 32'h00C0FFEE;
    push_txn(2'b01, 4'b1000, 32'h00C0FFEE, 1'b0);
    cyc(1);
    check("t5_ld_new", ld, 4'b1000);
    cyc(1);
    check("t5_ack_new", ack0, 1'b1);
    req0 = 1'b0;
    cyc(1);

`ifdef ARB_LOCK_EN
    // Lock keeps requester 0 for three writes, then requester 1 gets a turn.
    pulse_clear();
    lock0 = 1'b1;
    req0 = 1'b1; addr0 = 2'd0; data0 = 32'hAAAA0000;
    req1 = 1'b1; addr1 = 2'd1; data1 = 32'hBBBB0000;
    push_txn(2'b01, 4'b0001, 32'hAAAA0000, 1'b0);
    push_txn(2'b01, 4'b0001, 32'hAAAA0000, 1'b0);
    push_txn(2'b01, 4'b0001, 32'hAAAA0000, 1'b0);
    push_txn(2'b10, 4'b0010, 32'hBBBB0000, 1'b0);
    cyc(7);
    check("t6_gnt3", gnt, 2'b01);
    lock0 = 1'b0;
    cyc(4);
    check("t6_ack1", {ack1, ack0}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    cyc(1);
`endif

    cyc(2);
    check("sb_left", sbq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
